// File: rtl/apb_mem_slave_p.sv
// apb_mem_slave_p: parametrised APB3/APB4 memory-mapped slave used as a scratch/config RAM.
// Latency: the request is captured as the FSM leaves SETUP; PREADYs rises after WAIT_ST ACCESS cycles.
// Backpressure: PREADYs is held low during wait states; dropping PSELs/PENABLEs early aborts the transfer with PROT_VIOL.
//
// Ports:
//   CLK, Rst            clock (rising edge) and asynchronous active-low reset
//   PSELs, PENABLEs     APB select / access-phase enable
//   PWRITEs, PADDRs     direction (1 = write) and byte address
//   PWDATAs, PSTRBs     write data and byte-lane strobes
//   PREADYs, PRDATAs    transfer complete and read data (0 unless a good read completes)
//   PSLVerror           transfer error, qualified by PREADYs
//   PROT_VIOL           one-cycle pulse on an APB protocol violation
//   P_stsSLV            FSM state: IDLE=00, SETUP=01, ACCESS=10
//
// Build option: define APB_SLV_PSTRB_EN for APB4 byte-lane writes. In this build a read
// with non-zero PSTRBs is an error. Without it, PSTRBs is ignored and writes update
// every lane.
module apb_mem_slave_p #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int WAIT_ST   = 0,
  parameter int RESET_MEM = 1
) (
  input  logic                CLK,
  input  logic                Rst,
  input  logic                PSELs,
  input  logic                PENABLEs,
  input  logic                PWRITEs,
  input  logic [ADDR_W-1:0]   PADDRs,
  input  logic [DATA_W-1:0]   PWDATAs,
  input  logic [DATA_W/8-1:0] PSTRBs,
  output logic                PREADYs,
  output logic [DATA_W-1:0]   PRDATAs,
  output logic                PSLVerror,
  output logic                PROT_VIOL,
  output logic [1:0]          P_stsSLV
);

  localparam int NB     = DATA_W / 8;
  localparam int AL     = $clog2(NB);
  localparam int MIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Low address bits that must be zero for a word-aligned access (all zero when DATA_W=8).
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << AL) - 1);
  localparam logic [7:0]        WAIT_CNT   = 8'(WAIT_ST);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } state_t;

  state_t              state;
  logic [7:0]          cnt;
  logic                prot_viol_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   word_idx;
  logic [MIDX_W-1:0]   mem_idx;
  logic                misaligned;
  logic                out_of_range;
  logic                strb_err;
  logic                err;
  logic                ready;
  logic                mem_we;
  logic [DATA_W-1:0]   wr_word;

  // Error decode and memory indexing work on the latched address only, so address
  // changes on the bus during ACCESS have no effect.
  assign word_idx     = addr_q >> AL;
  assign mem_idx      = word_idx[MIDX_W-1:0];
  assign misaligned   = |(addr_q & ALIGN_MASK);
  assign out_of_range = 64'(word_idx) >= 64'(DEPTH);
  assign err          = misaligned | out_of_range | strb_err;

  assign ready  = (state == ST_ACCESS) && (cnt == WAIT_CNT);
  assign mem_we = ready && write_q && !err;

`ifdef APB_SLV_PSTRB_EN
  logic [NB-1:0] strb_q;

  // Merge enabled lanes into the current word; an all-zero strobe rewrites the old value.
  always_comb begin
    wr_word = mem[mem_idx];
    for (int i = 0; i < NB; i++) begin
      if (strb_q[i]) wr_word[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end
  assign strb_err = !write_q && (strb_q != '0);

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      strb_q <= '0;
    end else if (state == ST_SETUP && PSELs) begin
      strb_q <= PSTRBs;
    end
  end
`else
  logic unused_strb;
  assign unused_strb = ^PSTRBs;
  assign wr_word     = wdata_q;
  assign strb_err    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      prot_viol_q <= 1'b0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
    end else begin
      prot_viol_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (PSELs && !PENABLEs) begin
            state <= ST_SETUP;
          end else if (PSELs && PENABLEs) begin
            // Access phase without a preceding setup phase.
            prot_viol_q <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (PSELs) begin
            // Re-latched on every SETUP cycle so the request seen on the leaving edge wins.
            addr_q  <= PADDRs;
            write_q <= PWRITEs;
            wdata_q <= PWDATAs;
            cnt     <= '0;
            if (PENABLEs) state <= ST_ACCESS;
          end else begin
            state       <= ST_IDLE;
            prot_viol_q <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (ready) begin
            state <= (PSELs && !PENABLEs) ? ST_SETUP : ST_IDLE;
          end else if (!PSELs || !PENABLEs) begin
            // Master gave up before PREADYs: drop the transfer, nothing is written.
            state       <= ST_IDLE;
            prot_viol_q <= 1'b1;
          end else begin
            // !ready here implies cnt < WAIT_CNT, so this cannot overshoot.
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  generate
    if (RESET_MEM != 0) begin : g_mem_rst
      always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mem_we) begin
          mem[mem_idx] <= wr_word;
        end
      end
    end else begin : g_mem_norst
      always_ff @(posedge CLK) begin
        if (mem_we) mem[mem_idx] <= wr_word;
      end
    end
  endgenerate

  // Responses are decoded from registered state, so an async reset clears them at once.
  assign PREADYs   = ready;
  assign PSLVerror = ready && err;
  assign PRDATAs   = (ready && !write_q && !err) ? mem[mem_idx] : '0;
  assign PROT_VIOL = prot_viol_q;
  assign P_stsSLV  = state;

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// tb_apb_mem_slave_p: self-checking bench for apb_mem_slave_p (32-bit data, 32 words, 3 wait states).
// Latency: each transfer is expected to complete exactly WAIT_ST cycles after entering ACCESS.
// Backpressure: the bench master holds PSELs/PENABLEs until PREADYs, except in the abort scenarios.
module tb_apb_mem_slave_p;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int DEPTH     = 32;
  localparam int WAIT_ST   = 3;
  localparam int RESET_MEM = 1;
`ifdef APB_SLV_PSTRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              Rst = 1'b0;
  logic              PSELs = 1'b0;
  logic              PENABLEs = 1'b0;
  logic              PWRITEs = 1'b0;
  logic [ADDR_W-1:0] PADDRs = '0;
  logic [DATA_W-1:0] PWDATAs = '0;
  logic [3:0]        PSTRBs = '0;
  logic              PREADYs;
  logic [DATA_W-1:0] PRDATAs;
  logic              PSLVerror;
  logic              PROT_VIOL;
  logic [1:0]        P_stsSLV;

  int n_checks = 0;
  int n_errors = 0;

  // Reference memory: one 32-bit word per index, addressed as byte_address / 4.
  logic [31:0] ref_mem [DEPTH];

  apb_mem_slave_p #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .WAIT_ST(WAIT_ST), .RESET_MEM(RESET_MEM)
  ) u_dut (
    .CLK(CLK), .Rst(Rst),
    .PSELs(PSELs), .PENABLEs(PENABLEs), .PWRITEs(PWRITEs),
    .PADDRs(PADDRs), .PWDATAs(PWDATAs), .PSTRBs(PSTRBs),
    .PREADYs(PREADYs), .PRDATAs(PRDATAs), .PSLVerror(PSLVerror),
    .PROT_VIOL(PROT_VIOL), .P_stsSLV(P_stsSLV)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_err(input bit wr, input int unsigned addr, input logic [3:0] strb);
    bit e;
    e = (addr / 4 >= DEPTH) || (addr % 4 != 0);
    if (STRB_EN && !wr && strb != 4'h0) e = 1'b1;
    return e;
  endfunction

  task automatic ref_write(input int unsigned addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] w;
    w = ref_mem[addr / 4];
    for (int i = 0; i < 4; i++) begin
      if (!STRB_EN || strb[i]) w[8*i +: 8] = data[8*i +: 8];
    end
    ref_mem[addr / 4] = w;
  endtask

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
  endtask

  // One complete transfer; checks latency, response and return to IDLE, then updates the model.
  task automatic apb_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input string tag, output logic [31:0] rdata);
    bit          exp_err;
    logic [31:0] exp_rd;
    int          waits;
    exp_err = ref_err(wr, int'(addr), strb);
    exp_rd  = (!wr && !exp_err) ? ref_mem[int'(addr) / 4] : 32'h0;

    PSELs = 1'b1; PENABLEs = 1'b0; PWRITEs = wr;
    PADDRs = addr; PWDATAs = wdata; PSTRBs = strb;
    @(posedge CLK); #1;
    PENABLEs = 1'b1;
    @(posedge CLK); #1;
    check_eq({tag, " enter access"}, 64'(P_stsSLV), 64'(2'b10));
    waits = 0;
    while (!PREADYs && waits < 300) begin
      // Bus address/data wander during ACCESS; the slave must use what it latched.
      PADDRs  = 8'($urandom);
      PWDATAs = $urandom;
      @(posedge CLK); #1;
      waits++;
    end
    check_eq({tag, " wait cycles"}, 64'(waits), 64'(WAIT_ST));
    check_eq({tag, " pslverr"}, 64'(PSLVerror), 64'(exp_err));
    check_eq({tag, " prdata"}, 64'(PRDATAs), 64'(exp_rd));
    rdata = PRDATAs;
    @(posedge CLK); #1;
    if (wr && !exp_err) ref_write(int'(addr), wdata, strb);
    PSELs = 1'b0; PENABLEs = 1'b0;
    check_eq({tag, " back to idle"}, 64'(P_stsSLV), 64'(2'b00));
  endtask

  initial begin
    logic [31:0] rd;
    bit          wr;
    logic [7:0]  addr;
    logic [3:0]  strb;
    int          sel;

    ref_clear();

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check_eq("reset state", 64'(P_stsSLV), 64'(2'b00));
    check_eq("reset pready", 64'(PREADYs), 64'(0));
    check_eq("reset prdata", 64'(PRDATAs), 64'(0));
    check_eq("reset pslverr", 64'(PSLVerror), 64'(0));
    check_eq("reset prot_viol", 64'(PROT_VIOL), 64'(0));
    Rst = 1'b1;
    @(posedge CLK); #1;

    // Basic write then read-back
    apb_xfer(1'b1, 8'h08, 32'hDEADBEEF, 4'hF, "wr08", rd);
    apb_xfer(1'b0, 8'h08, 32'h0, 4'h0, "rd08", rd);
    check_eq("rd08 literal", 64'(rd), 64'(32'hDEADBEEF));
    apb_xfer(1'b1, 8'h04, 32'h0BADF00D, 4'hF, "wr04", rd);
    apb_xfer(1'b0, 8'h04, 32'h0, 4'h0, "rd04", rd);
    check_eq("rd04 literal", 64'(rd), 64'(32'h0BADF00D));

    // Out of range write, unchanged memory, misaligned read
    apb_xfer(1'b1, 8'h00, 32'h5A5A5A5A, 4'hF, "wr00", rd);
    apb_xfer(1'b1, 8'h80, 32'hFFFFFFFF, 4'hF, "wr80 oob", rd);
    apb_xfer(1'b0, 8'h00, 32'h0, 4'h0, "rd00 after oob", rd);
    check_eq("rd00 literal", 64'(rd), 64'(32'h5A5A5A5A));
    apb_xfer(1'b0, 8'h02, 32'h0, 4'h0, "rd02 misaligned", rd);
    check_eq("rd02 literal", 64'(rd), 64'(0));

    // Byte-lane strobes (full-word write when the feature is built out)
    apb_xfer(1'b1, 8'h0C, 32'h11223344, 4'hF, "wr0c full", rd);
    apb_xfer(1'b1, 8'h0C, 32'hAABBCCDD, 4'b0101, "wr0c strb", rd);
    apb_xfer(1'b0, 8'h0C, 32'h0, 4'h0, "rd0c", rd);
    check_eq("rd0c literal", 64'(rd), STRB_EN ? 64'(32'h11BB33DD) : 64'(32'hAABBCCDD));

    // Abort: PSELs dropped in ACCESS before PREADYs
    apb_xfer(1'b1, 8'h10, 32'h01020304, 4'hF, "wr10", rd);
    PSELs = 1'b1; PENABLEs = 1'b0; PWRITEs = 1'b1; PADDRs = 8'h10;
    PWDATAs = 32'hCAFEF00D; PSTRBs = 4'hF;
    @(posedge CLK); #1;
    PENABLEs = 1'b1;
    @(posedge CLK); #1;
    check_eq("abort in access", 64'(P_stsSLV), 64'(2'b10));
    check_eq("abort not ready", 64'(PREADYs), 64'(0));
    PSELs = 1'b0; PENABLEs = 1'b0;
    @(posedge CLK); #1;
    check_eq("abort prot_viol", 64'(PROT_VIOL), 64'(1));
    check_eq("abort state", 64'(P_stsSLV), 64'(2'b00));
    @(posedge CLK); #1;
    check_eq("abort prot_viol pulse", 64'(PROT_VIOL), 64'(0));
    apb_xfer(1'b0, 8'h10, 32'h0, 4'h0, "rd10 after abort", rd);
    check_eq("rd10 literal", 64'(rd), 64'(32'h01020304));

    // Access phase straight from IDLE
    PSELs = 1'b1; PENABLEs = 1'b1;
    @(posedge CLK); #1;
    check_eq("idle enable prot_viol", 64'(PROT_VIOL), 64'(1));
    check_eq("idle enable state", 64'(P_stsSLV), 64'(2'b00));
    PSELs = 1'b0; PENABLEs = 1'b0;
    @(posedge CLK); #1;
    check_eq("idle enable pulse end", 64'(PROT_VIOL), 64'(0));

    // Deselect while in SETUP
    PSELs = 1'b1; PENABLEs = 1'b0; PADDRs = 8'h18;
    @(posedge CLK); #1;
    check_eq("setup state", 64'(P_stsSLV), 64'(2'b01));
    PSELs = 1'b0;
    @(posedge CLK); #1;
    check_eq("setup drop prot_viol", 64'(PROT_VIOL), 64'(1));
    check_eq("setup drop state", 64'(P_stsSLV), 64'(2'b00));

    // Randomised traffic against the reference model
    for (int n = 0; n < 80; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      addr = 8'($urandom_range(0, 255));
      else if (sel == 1) addr = 8'(4 * $urandom_range(32, 63));
      else               addr = 8'(4 * $urandom_range(0, 31));
      wr   = 1'($urandom_range(0, 1));
      strb = 4'($urandom);
      if (!wr && $urandom_range(0, 4) != 0) strb = 4'h0;
      apb_xfer(wr, addr, $urandom, strb, $sformatf("rand%0d", n), rd);
    end

    // Reset asserted mid-ACCESS of a write, at the cycle PREADYs is high
    apb_xfer(1'b1, 8'h14, 32'h87654321, 4'hF, "wr14", rd);
    PSELs = 1'b1; PENABLEs = 1'b0; PWRITEs = 1'b1; PADDRs = 8'h14;
    PWDATAs = 32'h12345678; PSTRBs = 4'hF;
    @(posedge CLK); #1;
    PENABLEs = 1'b1;
    @(posedge CLK); #1;
    for (int k = 0; k < 300 && !PREADYs; k++) begin
      @(posedge CLK); #1;
    end
    check_eq("rst mid pready before", 64'(PREADYs), 64'(1));
    Rst = 1'b0;
    #1;
    check_eq("rst mid state", 64'(P_stsSLV), 64'(2'b00));
    check_eq("rst mid pready", 64'(PREADYs), 64'(0));
    check_eq("rst mid prdata", 64'(PRDATAs), 64'(0));
    check_eq("rst mid pslverr", 64'(PSLVerror), 64'(0));
    PSELs = 1'b0; PENABLEs = 1'b0;
    ref_clear();
    repeat (2) @(posedge CLK);
    #1;
    Rst = 1'b1;
    @(posedge CLK); #1;
    apb_xfer(1'b0, 8'h14, 32'h0, 4'h0, "rd14 after rst", rd);
    check_eq("rd14 literal", 64'(rd), 64'(0));
    apb_xfer(1'b0, 8'h08, 32'h0, 4'h0, "rd08 after rst", rd);
    check_eq("rd08 after rst literal", 64'(rd), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
